// File: rtl/fir_req_scheduler.sv
// fir_req_scheduler: sequences the shared FIR core. Arbitrates a sample stream and a
// coefficient-load requester onto the core's x_n bus and tvalid/set_coeffs strobes, and
// presents the core result on a one-cycle valid-pulsed port.
// Build option: define FIR_SCHED_STATS_EN to get a wrapping 16-bit result counter on
// sample_cnt; without it sample_cnt is tied to zero.
module fir_req_scheduler #(
    parameter int TAP_SIZE    = 3,
    parameter int NBR_OF_TAPS = 3,
    parameter int X_N_SIZE    = 8,
    parameter int Y_N_SIZE    = 11,
    parameter int INIT_CYCLES = 6,
    parameter int CORE_LAT    = 7,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                s_valid,
    input  logic signed [X_N_SIZE-1:0]          s_data,
    output logic                                s_ready,
    input  logic                                c_req,
    input  logic [NBR_OF_TAPS*TAP_SIZE-1:0]     c_coeffs,
    output logic                                c_ack,
    output logic signed [X_N_SIZE-1:0]          core_x_n,
    output logic                                core_tvalid,
    output logic                                core_set_coeffs,
    input  logic signed [Y_N_SIZE-1:0]          core_y_n,
    output logic                                m_valid,
    output logic signed [Y_N_SIZE-1:0]          m_data,
    output logic [15:0]                         sample_cnt
);
    localparam int CNT_W = 8;

    // ST_RES is the cycle CORE_LAT after the strobe, when the core result is presented.
    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_CFG, ST_SMP, ST_WAIT, ST_RES, ST_GAP
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            cfg_last_q, cfg_last_d;
    logic signed [X_N_SIZE-1:0]      smp_q, smp_d;
    logic [NBR_OF_TAPS*TAP_SIZE-1:0] coef_q, coef_d;
    logic signed [Y_N_SIZE-1:0]      m_data_q, m_data_d;

    // Selects tap idx from the latched coefficient word and sign-extends it to the bus width.
    function automatic logic signed [X_N_SIZE-1:0] tap_sext(
        input logic [NBR_OF_TAPS*TAP_SIZE-1:0] coeffs,
        input logic [CNT_W-1:0]                idx
    );
        logic [TAP_SIZE-1:0] tap;
        tap = '0;
        for (int k = 0; k < NBR_OF_TAPS; k++) begin
            if (idx == CNT_W'(k)) tap = coeffs[k*TAP_SIZE +: TAP_SIZE];
        end
        return {{(X_N_SIZE-TAP_SIZE){tap[TAP_SIZE-1]}}, tap};
    endfunction

    // Next-state, counters and all strobes; outputs default to zero outside their states.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cfg_last_d      = cfg_last_q;
        smp_d           = smp_q;
        coef_d          = coef_q;
        m_data_d        = m_data_q;
        s_ready         = 1'b0;
        c_ack           = 1'b0;
        core_tvalid     = 1'b0;
        core_set_coeffs = 1'b0;
        core_x_n        = '0;
        m_valid         = 1'b0;
        m_data          = m_data_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == CNT_W'(INIT_CYCLES-1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                // The priority bias toward samples only lasts for the first IDLE after a load.
                cfg_last_d = 1'b0;
                if (c_req && !(cfg_last_q && s_valid)) begin
                    state_d = ST_CFG;
                    cnt_d   = '0;
                    coef_d  = c_coeffs;
                end else if (s_valid) begin
                    s_ready = 1'b1;
                    smp_d   = s_data;
                    state_d = ST_SMP;
                end
            end
            ST_CFG: begin
                // Cycle 0 is setup; cycles 1..N shift tap[N-1] down to tap[0] into the core.
                if (cnt_q != '0) begin
                    core_set_coeffs = 1'b1;
                    core_x_n        = tap_sext(coef_q, CNT_W'(NBR_OF_TAPS) - cnt_q);
                end
                if (cnt_q == CNT_W'(NBR_OF_TAPS)) begin
                    c_ack      = 1'b1;
                    cfg_last_d = 1'b1;
                    state_d    = ST_GAP;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SMP: begin
                core_tvalid = 1'b1;
                core_x_n    = smp_q;
                state_d     = ST_WAIT;
                cnt_d       = '0;
            end
            ST_WAIT: begin
                core_x_n = smp_q;
                if (cnt_q == CNT_W'(CORE_LAT-2)) begin
                    state_d = ST_RES;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RES: begin
                // Result is passed through in its valid cycle and held afterwards.
                m_valid  = 1'b1;
                m_data   = core_y_n;
                m_data_d = core_y_n;
                state_d  = ST_GAP;
                cnt_d    = '0;
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES-1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state and the held result register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            cfg_last_q <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cfg_last_q <= cfg_last_d;
            m_data_q   <= m_data_d;
        end
    end

    // Sample and coefficient latches; only observed in states entered after a fresh load.
    always_ff @(posedge clk) begin
        smp_q  <= smp_d;
        coef_q <= coef_d;
    end

`ifdef FIR_SCHED_STATS_EN
    logic [15:0] sample_cnt_q, sample_cnt_d;

    // Counts delivered results; wraps naturally at 16 bits.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (m_valid) sample_cnt_d = sample_cnt_q + 16'd1;
    end

    // Result counter register.
    always_ff @(posedge clk) begin
        if (reset) sample_cnt_q <= '0;
        else       sample_cnt_q <= sample_cnt_d;
    end

    assign sample_cnt = sample_cnt_q;
`else
    assign sample_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fir_req_scheduler.sv
// Scoreboard bench for fir_req_scheduler: stimulus pushes expected core-bus events and
// timed probes; a negedge monitor pops and compares whenever the DUT shows activity.
module tb_fir_req_scheduler;
    localparam int CORE_LAT = 7;

    localparam int EV_CFG = 0, EV_ACK = 1, EV_SMP = 2, EV_RES = 3;
    localparam int PR_SRDY = 0, PR_ZERO = 1, PR_CNT = 2, PR_MHOLD = 3, PR_TMO = 4,
                   PR_EMPTY = 5, PR_ACK = 6;

    typedef struct { int kind; logic [15:0] val; } ev_t;
    typedef struct { int tgt; int kind; logic [15:0] val; } pr_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic        s_valid = 1'b0, s_ready, c_req = 1'b0, c_ack;
    logic [7:0]  s_data = 8'h00, core_x_n;
    logic [8:0]  c_coeffs = 9'h000;
    logic        core_tvalid, core_set_coeffs, m_valid;
    logic [10:0] core_y_n, m_data;
    logic [15:0] sample_cnt;

    ev_t ev_q[$];
    pr_t pr_q[$];
    int  cyc = 0;
    int  n_tests = 0, n_fail = 0;
    int  tv_cyc = -100;
    pr_t p;
    ev_t e;

    fir_req_scheduler dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .c_req(c_req), .c_coeffs(c_coeffs), .c_ack(c_ack), .core_x_n(core_x_n),
        .core_tvalid(core_tvalid), .core_set_coeffs(core_set_coeffs), .core_y_n(core_y_n),
        .m_valid(m_valid), .m_data(m_data), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: result is 3*x, valid exactly CORE_LAT cycles after tvalid, junk otherwise.
    logic [6:0] pv = '0;
    logic [7:0] px [7];
    always @(posedge clk) begin
        pv    <= {pv[5:0], core_tvalid === 1'b1};
        px[0] <= core_x_n;
        for (int i = 1; i < 7; i++) px[i] <= px[i-1];
    end
    function automatic logic [10:0] core_fn(input logic [7:0] x);
        logic signed [10:0] xs;
        xs = {{3{x[7]}}, x};
        return 11'(xs * 11'sd3);
    endfunction
    assign core_y_n = pv[6] ? core_fn(px[6]) : 11'h555;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input string name, input int kind, input logic [15:0] act);
        check({name, "_expected"}, 64'(ev_q.size() != 0), 64'd1);
        if (ev_q.size() != 0) begin
            e = ev_q.pop_front();
            check({name, "_kind"}, 64'(e.kind), 64'(kind));
            check({name, "_value"}, 64'(act), 64'(e.val));
        end
    endtask

    // Monitor: compare every strobe against the scoreboard and evaluate due probes.
    always @(negedge clk) begin
        if (core_tvalid === 1'b1 || core_set_coeffs === 1'b1)
            check("strobe_exclusive", 64'(core_tvalid & core_set_coeffs), 64'd0);
        if (core_set_coeffs === 1'b1) expect_ev("cfg", EV_CFG, {8'h00, core_x_n});
        if (c_ack === 1'b1)           expect_ev("ack", EV_ACK, 16'h0000);
        if (core_tvalid === 1'b1) begin
            expect_ev("smp", EV_SMP, {8'h00, core_x_n});
            tv_cyc = cyc;
        end
        if (m_valid === 1'b1) begin
            expect_ev("res", EV_RES, {5'h00, m_data});
            check("res_vs_core", 64'(m_data), 64'(core_y_n));
            check("res_latency", 64'(cyc - tv_cyc), 64'(CORE_LAT));
        end
        while (pr_q.size() != 0 && pr_q[0].tgt <= cyc) begin
            p = pr_q.pop_front();
            if (p.tgt < cyc) check("probe_timing", 64'(p.tgt), 64'(cyc));
            case (p.kind)
                PR_SRDY:  check("s_ready", 64'(s_ready), 64'(p.val[0]));
                PR_ZERO:  check("outputs_zero", 64'({s_ready, c_ack, core_tvalid, core_set_coeffs,
                                m_valid, core_x_n, m_data, sample_cnt}), 64'd0);
                PR_CNT:   check("sample_cnt", 64'(sample_cnt), 64'(p.val));
                PR_MHOLD: check("m_data_hold", 64'(m_data), 64'(p.val));
                PR_TMO:   check("wait_bound", 64'(p.val), 64'd1);
                PR_EMPTY: check("events_left", 64'(ev_q.size()), 64'd0);
                PR_ACK:   check("c_ack_timing", 64'(c_ack), 64'(p.val[0]));
                default:  check("probe_kind", 64'(p.kind), 64'd0);
            endcase
        end
    end

    task automatic probe(input int tgt, input int kind, input logic [15:0] val);
        pr_q.push_back('{tgt, kind, val});
    endtask

    // Wait (bounded) at negedges for s_ready (which=0) or c_ack (which=1).
    task automatic wait_sig(input int which, output int at);
        at = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((which == 0) ? (s_ready === 1'b1) : (c_ack === 1'b1)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) probe(cyc + 1, PR_TMO, 16'h0000);
    endtask

    task automatic send_sample(input logic [7:0] x, input logic [10:0] y, input bit exp_res);
        int at;
        ev_q.push_back('{EV_SMP, {8'h00, x}});
        if (exp_res) ev_q.push_back('{EV_RES, {5'h00, y}});
        s_data  = x;
        s_valid = 1'b1;
        wait_sig(0, at);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = 8'hA5;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r, a1, a2, a3;
        // Reset held with a pending sample: nothing may be accepted in reset or INIT.
        s_valid = 1'b1;
        s_data  = 8'h10;
        repeat (2) @(posedge clk); #1;
        for (int k = 0; k < 3; k++) probe(cyc + k, PR_ZERO, 16'h0);
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        r = cyc;
        for (int k = 0; k < 6; k++) probe(r + k, PR_SRDY, 16'h0);
        probe(r + 6, PR_SRDY, 16'h1);
        send_sample(8'h10, 11'h030, 1'b1);
        repeat (12) @(posedge clk); #1;
        probe(cyc, PR_MHOLD, 16'h0030);

        // Coefficient load; a change after grant must not affect the shifted values.
        ev_q.push_back('{EV_CFG, 16'h0003});
        ev_q.push_back('{EV_CFG, 16'h0002});
        ev_q.push_back('{EV_CFG, 16'h00FD});
        ev_q.push_back('{EV_ACK, 16'h0000});
        c_coeffs = 9'b011_010_101;
        c_req    = 1'b1;
        @(posedge clk); #1;
        c_coeffs = 9'h1FF;
        wait_sig(1, a1);
        @(posedge clk); #1;
        c_req = 1'b0;
        repeat (6) @(posedge clk); #1;

        // Negative and maximum positive samples.
        send_sample(8'hF0, 11'h7D0, 1'b1);
        repeat (12) @(posedge clk); #1;
        send_sample(8'h7F, 11'h17D, 1'b1);
        repeat (12) @(posedge clk); #1;

        // Both requests at once: load, one sample, then load again.
        ev_q.push_back('{EV_CFG, 16'h00FC});
        ev_q.push_back('{EV_CFG, 16'h00FF});
        ev_q.push_back('{EV_CFG, 16'h0001});
        ev_q.push_back('{EV_ACK, 16'h0000});
        ev_q.push_back('{EV_SMP, 16'h0022});
        ev_q.push_back('{EV_RES, 16'h0066});
        ev_q.push_back('{EV_CFG, 16'h00FC});
        ev_q.push_back('{EV_CFG, 16'h00FF});
        ev_q.push_back('{EV_CFG, 16'h0001});
        ev_q.push_back('{EV_ACK, 16'h0000});
        c_coeffs = 9'b100_111_001;
        c_req    = 1'b1;
        s_data   = 8'h22;
        s_valid  = 1'b1;
        wait_sig(1, a1);
        probe(a1 + 1, PR_SRDY, 16'h0);
        probe(a1 + 2, PR_SRDY, 16'h0);
        probe(a1 + 3, PR_SRDY, 16'h1);
        wait_sig(0, a2);
        probe(a2 + 14, PR_ACK, 16'h0);
        probe(a2 + 15, PR_ACK, 16'h1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = 8'hA5;
        wait_sig(1, a3);
        @(posedge clk); #1;
        c_req = 1'b0;
        repeat (6) @(posedge clk); #1;

        // Reset while waiting on the core: result is dropped, service resumes after INIT.
        ev_q.push_back('{EV_SMP, 16'h0005});
        s_data  = 8'h05;
        s_valid = 1'b1;
        wait_sig(0, a1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        probe(cyc, PR_ZERO, 16'h0);
        reset = 1'b0;
        r = cyc;
        for (int k = 1; k < 6; k++) probe(r + k, PR_SRDY, 16'h0);
        probe(r + 6, PR_SRDY, 16'h1);
        send_sample(8'h7F, 11'h17D, 1'b1);
        repeat (12) @(posedge clk); #1;

        // Result counter over three samples from a fresh reset.
        reset = 1'b1;
        @(posedge clk); #1;
        probe(cyc, PR_ZERO, 16'h0);
        reset = 1'b0;
        send_sample(8'h01, 11'h003, 1'b1);
        repeat (12) @(posedge clk); #1;
        send_sample(8'h80, 11'h680, 1'b1);
        repeat (12) @(posedge clk); #1;
        send_sample(8'h55, 11'h0FF, 1'b1);
        repeat (12) @(posedge clk); #1;
`ifdef FIR_SCHED_STATS_EN
        probe(cyc, PR_CNT, 16'd3);
`else
        probe(cyc, PR_CNT, 16'd0);
`endif
        probe(cyc + 1, PR_EMPTY, 16'h0);
        repeat (3) @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
